// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO controller: default widths, pointer/count
// types and the wrap-bit full/empty compare.
package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 13;

  typedef logic [DEFAULT_ADDR_WIDTH:0] ptr_t;
  typedef logic [DEFAULT_ADDR_WIDTH:0] count_t;

  function automatic logic ptrEmpty(ptr_t wr, ptr_t rd);
    return wr == rd;
  endfunction

  // Full means the low address bits match but the wrap bit (bit aw) differs.
  function automatic logic ptrFull(ptr_t wr, ptr_t rd, int aw);
    return (wr ^ rd) == (ptr_t'(1) << aw);
  endfunction

endpackage

// File: rtl/fifo_ctrl_if.sv
// Producer/consumer streaming handshakes plus the dual-port RAM port signals
// driven by fifo_ctrl; slave is the controller's view, master the environment's.
interface fifo_ctrl_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);

  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH-1:0] ram_wr_addr;
  logic [DATA_WIDTH-1:0] ram_wr_data;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_rd_addr;
  logic [DATA_WIDTH-1:0] ram_rd_data;

  modport slave (
    input  in_data, in_valid, out_ready, ram_rd_data,
    output in_ready, out_data, out_valid, ram_wr_addr, ram_wr_data, ram_we, ram_rd_addr
  );

  modport master (
    output in_data, in_valid, out_ready, ram_rd_data,
    input  in_ready, out_data, out_valid, ram_wr_addr, ram_wr_data, ram_we, ram_rd_addr
  );

endinterface

// File: rtl/fifo_ptr.sv
// FIFO pointer register: wrapping increment with synchronous clear; clear wins
// over increment.
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int W = DEFAULT_ADDR_WIDTH + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_ptr
);

  logic [W-1:0] r_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_clr) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= r_ptr + W'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/fifo_ctrl.sv
// Synchronous show-ahead FIFO controller driving an external dual-port RAM.
// Define FIFO_CTRL_HWM_EN to add the hwm and overflow_sticky outputs.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
  parameter int AFULL_THRESH = (1 << ADDR_WIDTH) - 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  fifo_ctrl_if.slave          bus,
  output logic [ADDR_WIDTH:0] count,
  output logic                almost_full
`ifdef FIFO_CTRL_HWM_EN
  ,
  output logic [ADDR_WIDTH:0] hwm,
  output logic                overflow_sticky
`endif
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] AFULL_C = CW'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] ONE_C   = CW'(1);

  logic [ADDR_WIDTH:0] w_wrPtr;
  logic [ADDR_WIDTH:0] w_rdPtr;
  logic [ADDR_WIDTH:0] w_countNext;
  logic [ADDR_WIDTH:0] r_count;
  logic                r_afull;
  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;

  // Flags depend only on the pointer registers, so in_ready never sees out_ready.
  assign w_full  = ptrFull(ptr_t'(w_wrPtr), ptr_t'(w_rdPtr), ADDR_WIDTH);
  assign w_empty = ptrEmpty(ptr_t'(w_wrPtr), ptr_t'(w_rdPtr));
  assign w_push  = bus.in_valid & ~w_full;
  assign w_pop   = bus.out_ready & ~w_empty;

  assign bus.in_ready    = ~w_full;
  assign bus.out_valid   = ~w_empty;
  assign bus.out_data    = bus.ram_rd_data;
  assign bus.ram_we      = w_push & ~flush;
  assign bus.ram_wr_addr = w_wrPtr[ADDR_WIDTH-1:0];
  assign bus.ram_wr_data = bus.in_data;
  assign bus.ram_rd_addr = w_rdPtr[ADDR_WIDTH-1:0];

  fifo_ptr #(.W(CW)) u_wrPtr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (flush),
    .i_inc (w_push),
    .o_ptr (w_wrPtr)
  );

  fifo_ptr #(.W(CW)) u_rdPtr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (flush),
    .i_inc (w_pop),
    .o_ptr (w_rdPtr)
  );

  always_comb begin
    w_countNext = r_count;
    if (flush) begin
      w_countNext = '0;
    end else if (w_push && !w_pop) begin
      w_countNext = r_count + ONE_C;
    end else if (w_pop && !w_push) begin
      w_countNext = r_count - ONE_C;
    end
  end

  // almost_full is derived from the next count so it changes on the same edge as count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_afull <= 1'b0;
    end else begin
      r_count <= w_countNext;
      r_afull <= (w_countNext >= AFULL_C);
    end
  end

  assign count       = r_count;
  assign almost_full = r_afull;

`ifdef FIFO_CTRL_HWM_EN
  logic [ADDR_WIDTH:0] r_hwm;
  logic                r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hwm <= '0;
      r_ovf <= 1'b0;
    end else if (flush) begin
      r_hwm <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_countNext > r_hwm) begin
        r_hwm <= w_countNext;
      end
      if (bus.in_valid && w_full) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign hwm             = r_hwm;
  assign overflow_sticky = r_ovf;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl (8-entry build) with a behavioural RAM and a
// queue-based reference model.
module tb_fifo_ctrl;
  import fifo_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;

  typedef struct {
    logic       fl;
    logic       iv;
    logic [7:0] d;
    logic       rdy;
    int         expCount;
    logic       expOv;
    logic [7:0] expOd;
    logic       expIr;
    logic       expAf;
  } vec_t;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic [AW:0]   count;
  logic          almost_full;
`ifdef FIFO_CTRL_HWM_EN
  logic [AW:0]   hwm;
  logic          overflow_sticky;
`endif

  fifo_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush           (flush),
    .bus             (bus),
    .count           (count),
    .almost_full     (almost_full)
`ifdef FIFO_CTRL_HWM_EN
    ,
    .hwm             (hwm),
    .overflow_sticky (overflow_sticky)
`endif
  );

  logic [DW-1:0] mem [DEPTH];

  always @(posedge clk) begin
    if (bus.ram_we === 1'b1) mem[bus.ram_wr_addr] <= bus.ram_wr_data;
  end
  assign bus.ram_rd_data = mem[bus.ram_rd_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         total;
  int         bad;
  logic [7:0] q [$];
  int         wrIdx;
  int         rdIdx;
  int         hwmM;
  bit         ovfM;

  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    q.delete();
    wrIdx = 0;
    rdIdx = 0;
    hwmM  = 0;
    ovfM  = 1'b0;
  endtask

  task automatic modelUpdate(input logic fl, input logic iv, input logic [7:0] d, input logic rdy);
    int n = q.size();
    if (fl) begin
      modelReset();
    end else begin
      if (iv && n == DEPTH) ovfM = 1'b1;
      if (rdy && n > 0) begin
        void'(q.pop_front());
        rdIdx++;
      end
      if (iv && n < DEPTH) begin
        q.push_back(d);
        wrIdx++;
      end
      if (q.size() > hwmM) hwmM = q.size();
    end
  endtask

  task automatic checkOutput(input logic fl, input logic iv, input logic [7:0] d);
    int n = q.size();
    bit expWe = !fl && iv && (n < DEPTH);
    checkEq("in_ready", 32'(bus.in_ready), 32'(n < DEPTH));
    checkEq("out_valid", 32'(bus.out_valid), 32'(n > 0));
    if (n > 0) checkEq("out_data", 32'(bus.out_data), 32'(q[0]));
    checkEq("count", 32'(count), 32'(n));
    checkEq("almost_full", 32'(almost_full), 32'(n >= DEPTH - 4));
    checkEq("ram_we", 32'(bus.ram_we), 32'(expWe));
    checkEq("ram_wr_addr", 32'(bus.ram_wr_addr), 32'(wrIdx % DEPTH));
    checkEq("ram_rd_addr", 32'(bus.ram_rd_addr), 32'(rdIdx % DEPTH));
    if (expWe) checkEq("ram_wr_data", 32'(bus.ram_wr_data), 32'(d));
`ifdef FIFO_CTRL_HWM_EN
    checkEq("hwm", 32'(hwm), 32'(hwmM));
    checkEq("overflow_sticky", 32'(overflow_sticky), 32'(ovfM));
`endif
  endtask

  // Called at posedge+1: drive inputs, compare against the model mid-cycle, then advance.
  task automatic applyStimulus(input logic fl, input logic iv, input logic [7:0] d, input logic rdy);
    flush        = fl;
    bus.in_valid = iv;
    bus.in_data  = d;
    bus.out_ready = rdy;
    @(negedge clk);
    checkOutput(fl, iv, d);
    @(posedge clk);
    modelUpdate(fl, iv, d, rdy);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t       tbl [$];
    logic [7:0] w;
    int         addr;

    total = 0;
    bad   = 0;
    modelReset();
    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkEq("reset_in_ready", 32'(bus.in_ready), 32'd1);
    checkEq("reset_out_valid", 32'(bus.out_valid), 32'd0);
    checkEq("reset_count", 32'(count), 32'd0);
    checkEq("reset_almost_full", 32'(almost_full), 32'd0);
    checkEq("reset_ram_we", 32'(bus.ram_we), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkEq("idle_in_ready", 32'(bus.in_ready), 32'd1);
    checkEq("idle_out_valid", 32'(bus.out_valid), 32'd0);
    checkEq("idle_count", 32'(count), 32'd0);

    // fl, iv, d, rdy : count, out_valid, out_data, in_ready, almost_full
    tbl.push_back('{1'b0, 1'b1, 8'h11, 1'b0, 1, 1'b1, 8'h11, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 8'h22, 1'b0, 2, 1'b1, 8'h11, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 8'h33, 1'b0, 3, 1'b1, 8'h11, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 2, 1'b1, 8'h22, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1, 1'b1, 8'h33, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 8'hA0, 1'b0, 1, 1'b1, 8'hA0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 8'hA1, 1'b0, 2, 1'b1, 8'hA0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 8'hA2, 1'b0, 3, 1'b1, 8'hA0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 8'hA3, 1'b0, 4, 1'b1, 8'hA0, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 8'hA4, 1'b0, 5, 1'b1, 8'hA0, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 8'hA5, 1'b0, 6, 1'b1, 8'hA0, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 8'hA6, 1'b0, 7, 1'b1, 8'hA0, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 8'hA7, 1'b0, 8, 1'b1, 8'hA0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 8'hFF, 1'b0, 8, 1'b1, 8'hA0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 8'hB0, 1'b1, 7, 1'b1, 8'hA1, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 8'hB0, 1'b1, 7, 1'b1, 8'hA2, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 6, 1'b1, 8'hA3, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 5, 1'b1, 8'hA4, 1'b1, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 8'hEE, 1'b1, 0, 1'b0, 8'h00, 1'b1, 1'b0});

    foreach (tbl[i]) begin
      applyStimulus(tbl[i].fl, tbl[i].iv, tbl[i].d, tbl[i].rdy);
      checkEq($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].expCount));
      checkEq($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'(tbl[i].expOv));
      if (tbl[i].expOv) checkEq($sformatf("vec%0d_out_data", i), 32'(bus.out_data), 32'(tbl[i].expOd));
      checkEq($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'(tbl[i].expIr));
      checkEq($sformatf("vec%0d_almost_full", i), 32'(almost_full), 32'(tbl[i].expAf));
    end

    // Streaming through the pointer wrap: 20 words, one pushed and one popped per cycle.
    for (int i = 0; i <= 20; i++) begin
      if (i < 20) checkEq("wrap_wr_addr", 32'(bus.ram_wr_addr), 32'(i % DEPTH));
      if (i > 0) begin
        w = 8'((i - 1) * 7 + 3);
        checkEq("wrap_data", 32'(bus.out_data), 32'(w));
      end
      applyStimulus(1'b0, (i < 20), 8'(i * 7 + 3), (i > 0));
    end
    checkEq("wrap_final_count", 32'(count), 32'd0);

    for (int k = 0; k < 5; k++) applyStimulus(1'b0, 1'b1, 8'(8'h51 + k), 1'b0);
    checkEq("preflush_count", 32'(count), 32'd5);
`ifdef FIFO_CTRL_HWM_EN
    checkEq("preflush_hwm", 32'(hwm), 32'd5);
`endif
    addr = wrIdx % DEPTH;
    applyStimulus(1'b1, 1'b1, 8'h99, 1'b0);
    checkEq("flush_count", 32'(count), 32'd0);
    checkEq("flush_out_valid", 32'(bus.out_valid), 32'd0);
    checkEq("flush_no_ram_write", 32'(mem[addr] === 8'h99), 32'd0);
`ifdef FIFO_CTRL_HWM_EN
    checkEq("flush_hwm", 32'(hwm), 32'd0);
    checkEq("flush_overflow", 32'(overflow_sticky), 32'd0);
`endif

    for (int k = 0; k < 400; k++) begin
      logic fl;
      logic iv;
      logic rdy;
      fl  = ($urandom_range(0, 31) == 0);
      iv  = (k < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      rdy = (k < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      applyStimulus(fl, iv, 8'($urandom), rdy);
      if (k == 150) begin
        // Asynchronous reset in the middle of a cycle with data in flight.
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        modelReset();
        checkEq("midreset_count", 32'(count), 32'd0);
        checkEq("midreset_out_valid", 32'(bus.out_valid), 32'd0);
        checkEq("midreset_in_ready", 32'(bus.in_ready), 32'd1);
        checkEq("midreset_almost_full", 32'(almost_full), 32'd0);
        checkEq("midreset_ram_we", 32'(bus.ram_we), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Synchronous FIFO controller; sits directly upstream of the team's dual-port RAM (one synchronous write port, one asynchronous read port) and drives both of its ports.
- Owns read/write pointers, occupancy count and full/empty flags.
- Exposes valid/ready streaming handshakes to producer and consumer.
- Show-ahead read: head word visible on out_data whenever out_valid=1, fed combinationally from RAM read data.

Parameters:
DATA_WIDTH, 8, word width; must match RAM DATA_WIDTH.
ADDR_WIDTH, 13, RAM address width; depth = 2**ADDR_WIDTH.
AFULL_THRESH, (1<<ADDR_WIDTH)-4, almost_full asserts when count >= this value.

Ports:
clk  input  1  system clock, all state on rising edge.
rst_n  input  1  asynchronous active-low reset.
flush  input  1  synchronous clear of FIFO contents.
in_data  input  DATA_WIDTH  producer write data.
in_valid  input  1  producer has a word.
in_ready  output  1  FIFO accepts a word this cycle.
out_data  output  DATA_WIDTH  head-of-FIFO word.
out_valid  output  1  out_data is valid.
out_ready  input  1  consumer takes head word this cycle.
ram_wr_addr  output  ADDR_WIDTH  to RAM write-port address.
ram_wr_data  output  DATA_WIDTH  to RAM write-port data.
ram_we  output  1  to RAM write enable.
ram_rd_addr  output  ADDR_WIDTH  to RAM read-port address.
ram_rd_data  input  DATA_WIDTH  from RAM asynchronous read data.
count  output  ADDR_WIDTH+1  current occupancy, 0..2**ADDR_WIDTH.
almost_full  output  1  count >= AFULL_THRESH.

Behaviour:
- Clock clk; reset rst_n asynchronous, active-low.
- Reset values: wr_ptr=0, rd_ptr=0, count=0.
  - Outputs: in_ready=1, out_valid=0, almost_full=0, ram_we=0.
- Pointers are ADDR_WIDTH+1 bits; the MSB is the wrap bit.
  - empty: wr_ptr==rd_ptr.
  - full: low bits equal and MSBs differ.
- push = in_valid & in_ready.
  - in_ready = !full, registered-derived only; no combinational path from out_ready.
- pop = out_valid & out_ready; out_valid = !empty.
- ram_wr_addr=wr_ptr[ADDR_WIDTH-1:0], ram_wr_data=in_data, ram_we=push & !flush.
- ram_rd_addr=rd_ptr[ADDR_WIDTH-1:0]; out_data=ram_rd_data (combinational passthrough).
- Latency: a word pushed at edge N is visible with out_valid=1 after edge N (next cycle); no same-cycle fall-through when empty.
- count update:
  - push only: +1.
  - pop only: -1.
  - push and pop: unchanged.
  - Both pointers still advance as applicable.
- Full: no push even if pop is asserted the same cycle; in_ready rises the cycle after a pop.
- Empty: no pop (out_valid=0); out_ready ignored.
- Wrap-around: pointers increment modulo 2**(ADDR_WIDTH+1); the low bits wrap naturally, with no special case.
- flush=1: next edge sets wr_ptr=rd_ptr=0, count=0.
  - flush overrides push/pop in the same cycle; ram_we is forced 0.
- Reset mid-operation: state returns to reset values immediately; RAM contents are irrelevant because data is never read while empty.
- almost_full is registered, computed from next-state count, so it is cycle-aligned with count.

Optional Feature:
- Macro FIFO_CTRL_HWM_EN.
- Defined:
  - Adds output hwm[ADDR_WIDTH:0], a high-water mark holding the max count since reset or flush.
  - Updated at the same edge as count; cleared to 0 by rst_n and by flush.
  - Adds output overflow_sticky, set when in_valid=1 while full; cleared only by rst_n or flush.
- Not defined: neither port exists and no extra logic is generated.

Decomposition:
- Shared package fifo_pkg holds:
  - default DATA_WIDTH/ADDR_WIDTH constants.
  - pointer typedef (ADDR_WIDTH+1 bits).
  - count typedef.
  - full/empty compare function.
- One natural sub-module: fifo_ptr, a pointer register with increment enable and sync clear, instantiated for read and write.
- The RAM is instantiated alongside, not inside, fifo_ctrl.

Test Plan:
- Reset then idle -> in_ready=1, out_valid=0, count=0, almost_full=0, ram_we=0.
- Push 0x11,0x22,0x33 with out_ready=0 -> count=3; out_data=0x11 the cycle after the first push; pops then return 0x11,0x22,0x33 in order, count back to 0.
- ADDR_WIDTH=3: push 8 words -> in_ready=0 and count=8; extra in_valid does not write (ram_we=0); almost_full high from count 4 (default thresh).
- Full FIFO with in_valid=1 and out_ready=1 -> cycle 1 pop only, count=7; cycle 2 push and pop together, count stays 7.
- Wrap, ADDR_WIDTH=3: stream 20 words with continuous push/pop -> data order preserved across pointer wrap; ram_wr_addr sequence wraps 7->0.
- Flush with count=5 and push asserted -> next cycle count=0, out_valid=0, no RAM write.
  - With FIFO_CTRL_HWM_EN: hwm reads 5 before the flush, 0 after it.
